// File: rtl/gpio_pkg.sv
// gpio_pkg: shared widths, BCD FSM state type and the double-dabble digit adjust
package gpio_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int BCD_DIGITS = 10;
  localparam int BCD_WIDTH  = 4 * BCD_DIGITS;

  typedef enum logic {IDLE, CONV} bcd_state_t;

  function automatic logic [BCD_WIDTH-1:0] dd_adjust(input logic [BCD_WIDTH-1:0] a);
    logic [BCD_WIDTH-1:0] r;
    r = a;
    for (int i = 0; i < BCD_DIGITS; i++)
      r[i*4 +: 4] = (a[i*4 +: 4] >= 4'd5) ? a[i*4 +: 4] + 4'd3 : a[i*4 +: 4];
    return r;
  endfunction
endpackage

// File: rtl/gpio_periph_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle, 32 cycles per conversion
module bin2bcd_seq
  import gpio_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BCD_WIDTH-1:0]  o_bcd
);
  bcd_state_t                r_state;
  logic [DATA_WIDTH-1:0]     r_shreg;
  logic [BCD_WIDTH-1:0]      r_acc;
  logic [4:0]                r_step;
  logic [BCD_WIDTH-1:0]      w_adj;
  logic [BCD_WIDTH-1:0]      w_acc_next;
  logic [DATA_WIDTH-1:0]     w_sh_next;

  assign w_adj      = dd_adjust(r_acc);
  assign w_acc_next = {w_adj[BCD_WIDTH-2:0], r_shreg[DATA_WIDTH-1]};
  assign w_sh_next  = {r_shreg[DATA_WIDTH-2:0], 1'b0};
  assign o_busy     = (r_state == CONV);
  assign o_done     = o_busy && (r_step == 5'd31);

  // capture on start, then adjust+shift every cycle; publish the result only when complete
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_acc   <= '0;
      r_step  <= '0;
      o_bcd   <= '0;
    end else if (r_state == IDLE) begin
      if (i_start) begin
        r_shreg <= i_din;
        r_acc   <= '0;
        r_step  <= '0;
        r_state <= CONV;
      end
    end else begin
      r_acc   <= w_acc_next;
      r_shreg <= w_sh_next;
      r_step  <= r_step + 5'd1;
      if (r_step == 5'd31) begin
        o_bcd   <= w_acc_next;
        r_state <= IDLE;
      end
    end
endmodule

// File: rtl/gpio_periph.sv
// gpio_periph: switch sync/debounce to gpio_in, gpio_out to BCD; GPIO_DEBOUNCE_EN enables debounce
module gpio_periph
  import gpio_pkg::*;
#(
  parameter int SW_WIDTH        = 18,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SW_WIDTH-1:0]   sw,
  output logic [DATA_WIDTH-1:0] gpio_in,
  input  logic [DATA_WIDTH-1:0] gpio_out,
  output logic [BCD_WIDTH-1:0]  bcd,
  output logic                  bcd_valid
);
  logic [SW_WIDTH-1:0]   r_sync1;
  logic [SW_WIDTH-1:0]   r_sync2;
  logic [DATA_WIDTH-1:0] r_src_q;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_start;

  if (SW_WIDTH > DATA_WIDTH || SW_WIDTH < 1 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
    $error("gpio_periph: SW_WIDTH must be 1..32 and DEBOUNCE_CYCLES >= 2");
  end

  // two-flop synchronizer for the asynchronous switch pins
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [SW_WIDTH-1:0] r_cand;
  logic [SW_WIDTH-1:0] r_deb;
  logic [CW-1:0]       r_cnt;

  // whole vector must hold still for DEBOUNCE_CYCLES cycles; any bit change restarts the window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_deb  <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_deb  <= r_cand;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end

  assign gpio_in = DATA_WIDTH'(r_deb);
`else
  assign gpio_in = DATA_WIDTH'(r_sync2);
`endif

  assign w_start = !w_busy && (gpio_out != r_src_q);

  // remember which value is being converted; bcd is stale from start until done
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_src_q   <= '0;
      bcd_valid <= 1'b1;
    end else if (w_start) begin
      r_src_q   <= gpio_out;
      bcd_valid <= 1'b0;
    end else if (w_done) begin
      bcd_valid <= 1'b1;
    end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_din   (gpio_out),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (bcd)
  );
endmodule
